// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler that shares one shift_add_mult among
// NUM_REQ requesters and returns each product with the owner's index.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    per-requester handshake, at most one ready bit high
//   req_a, req_b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_signed         per-requester signed mode
//   rsp_valid/ready    response handshake
//   rsp_id             owner of the response
//   rsp_result         product
//   rsp_err            watchdog abort flag
//   mul_*              connection to the shared multiplier
//
// Build option: define MULT_SCHED_TIMEOUT_EN to enable a WAIT watchdog
// that aborts after TIMEOUT cycles with rsp_err=1 and rsp_result=0.
// Without it rsp_err is tied 0 and WAIT lasts until mul_done.
module mult_sched #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_signed,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     rsp_err,
    output logic                     mul_start,
    output logic                     mul_valid_in,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_signed,
    input  logic [2*WIDTH-1:0]       mul_result,
    input  logic                     mul_done,
    input  logic                     mul_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // One extra bit so ptr + k can be folded back modulo NUM_REQ.
    localparam int SW = IDW + 1;
    localparam logic [SW-1:0]  NUM_W   = SW'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    state_t state;
    state_t state_nxt;

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   cur_id;
    logic [IDW-1:0]   win;
    logic [SW-1:0]    scan;
    logic             found;
    logic             grant;
    logic             to_hit;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             win_s;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin : arb
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + SW'(k);
            if (scan >= NUM_W) begin
                scan = scan - NUM_W;
            end
            if (!found && req_valid[scan[IDW-1:0]]) begin
                found = 1'b1;
                win   = scan[IDW-1:0];
            end
        end
    end

    always_comb begin : opsel
        win_a = '0;
        win_b = '0;
        win_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDW'(i)) begin
                win_a = req_a[i*WIDTH +: WIDTH];
                win_b = req_b[i*WIDTH +: WIDTH];
                win_s = req_signed[i];
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin : fsm
        state_nxt = state;
        grant     = 1'b0;
        mul_start = 1'b0;
        req_ready = '0;
        unique case (state)
            IDLE: begin
                if (!rst && found && !mul_busy) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mul_done || to_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (win == IDW'(i));
        end
    end

    assign mul_valid_in = mul_start;
    assign rsp_valid    = (state == RESP);

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] wd_cnt;
    logic          err_q;

    // Counts completed WAIT cycles; cleared whenever WAIT is not active.
    always_ff @(posedge clk) begin : watchdog
        if (rst || state != WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign to_hit  = (state == WAIT) && !mul_done
                     && (wd_cnt == CW'(TIMEOUT - 1));
    assign rsp_err = err_q;
`else
    assign to_hit  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            ptr        <= '0;
            cur_id     <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            // Operands go straight to the multiplier pins and stay there
            // through ISSUE and WAIT.
            if (grant) begin
                mul_a      <= win_a;
                mul_b      <= win_b;
                mul_signed <= win_s;
                cur_id     <= win;
            end
            if (state == WAIT && mul_done) begin
                rsp_result <= mul_result;
                rsp_id     <= cur_id;
`ifdef MULT_SCHED_TIMEOUT_EN
                err_q      <= 1'b0;
`endif
            end
`ifdef MULT_SCHED_TIMEOUT_EN
            else if (to_hit) begin
                rsp_result <= '0;
                rsp_id     <= cur_id;
                err_q      <= 1'b1;
            end
`endif
            // Fairness pointer moves only once the response is consumed.
            if (state == RESP && rsp_ready) begin
                if (cur_id == LAST_ID) begin
                    ptr <= '0;
                end else begin
                    ptr <= cur_id + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed and random stimulus for mult_sched against a
// behavioural multiplier and a round-robin/product reference model.
module tb_mult_sched;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_signed;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [2*W-1:0] rsp_result;
    logic           rsp_err;
    logic           mul_start;
    logic           mul_valid_in;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_signed;
    logic [2*W-1:0] mul_result;
    logic           mul_done;
    logic           mul_busy;

    always #5 clk = ~clk;

    mult_sched #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_valid_in(mul_valid_in),
        .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed),
        .mul_result(mul_result), .mul_done(mul_done), .mul_busy(mul_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic s);
        longint x;
        longint y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 32'(x * y);
    endfunction

    // Behavioural multiplier: random latency, product from the pins it
    // sees when finishing, random garbage on mul_result otherwise.
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_res  = '0;
    logic           spur = 1'b0;
    logic           force_busy = 1'b0;
    logic           no_done = 1'b0;
    int             lat = 0;
    int             starts = 0;
    int             ncyc = 0;
    int             done_cyc = -10;

    assign mul_busy   = m_busy | force_busy;
    assign mul_done   = m_done | spur;
    assign mul_result = m_res;

    always begin
        @(negedge clk);
        ncyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
            m_res  = $urandom;
        end else if (m_busy) begin
            if (!no_done) begin
                if (lat == 0) begin
                    m_done   = 1'b1;
                    m_res    = ref_prod(mul_a, mul_b, mul_signed);
                    done_cyc = ncyc;
                end else begin
                    lat--;
                end
            end
        end else if (mul_start) begin
            m_busy = 1'b1;
            starts++;
            lat = $urandom_range(0, 5);
        end
    end

    int          ptr_m = 0;
    logic [31:0] last_res;

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [15:0] a,
                           input logic [15:0] b, input logic s);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_signed[i]   = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        ptr_m = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rsp"}, {req_ready, rsp_valid, rsp_id, rsp_result, rsp_err}, 0);
        chk({tag, "_mul"}, {mul_start, mul_valid_in, mul_a, mul_b, mul_signed}, 0);
    endtask

    // Called at a negedge with requests set; returns at a negedge after
    // the response has been consumed.
    task automatic run_txn(input int rdy_delay, input logic [N-1:0] persist,
                           output int got_id, output int wait_cyc);
        int          w;
        int          exp_id;
        int          s0;
        bit          granted;
        logic [31:0] exp_r;
        granted = 0;
        w = 0;
        got_id = -1;
        while (!granted && w < 50) begin
            #1;
            if (req_ready != '0) granted = 1;
            else begin
                w++;
                @(negedge clk);
            end
        end
        wait_cyc = w;
        if (!granted) begin
            chk("grant_timeout", 0, 1);
            return;
        end
        exp_id = rr_pick(req_valid, ptr_m);
        if (exp_id < 0) exp_id = 0;
        chk("grant_onehot", req_ready, 1 << exp_id);
        exp_r = ref_prod(req_a[exp_id*W +: W], req_b[exp_id*W +: W],
                         req_signed[exp_id]);
        s0 = starts;
        @(negedge clk);
        #1;
        chk("issue", {mul_start, mul_valid_in, req_ready}, {2'b11, 4'b0});
        if (!persist[exp_id]) req_valid[exp_id] = 1'b0;
        w = 0;
        while (rsp_valid !== 1'b1 && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("rsp_seen", rsp_valid, 1);
        chk("rsp_lat", ncyc - done_cyc, 1);
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_result", rsp_result, exp_r);
        chk("rsp_err", rsp_err, 0);
        chk("one_start", starts - s0, 1);
        got_id   = int'(rsp_id);
        last_res = rsp_result;
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge clk);
            #1;
            chk("resp_hold",
                {rsp_valid, rsp_id, rsp_result, rsp_err, req_ready, mul_start},
                {1'b1, 2'(exp_id), exp_r, 1'b0, 4'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ptr_m = (exp_id + 1) % N;
    endtask

    initial begin
        int  id;
        int  w;
        int  n0;
        bit  quiet;
        logic [N-1:0] mask;

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_signed = '0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst   = 1'b0;
        ptr_m = 0;

        // Multiplier busy blocks grants in IDLE.
        set_req(0, 16'd7, 16'd9, 1'b0);
        req_valid  = 4'b0001;
        force_busy = 1'b1;
        quiet = 1;
        repeat (3) begin
            #1;
            if (req_ready !== '0) quiet = 0;
            @(negedge clk);
        end
        chk("busy_no_grant", quiet, 1);
        force_busy = 1'b0;
        run_txn(1, '0, id, w);
        chk("busy_then_id", id, 0);

        // Stray mul_done in IDLE is ignored.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        #1;
        chk("spur_done", rsp_valid, 0);
        @(negedge clk);

        // Single requester 2.
        set_req(2, 16'd1000, 16'd100, 1'b0);
        req_valid = 4'b0100;
        run_txn(0, '0, id, w);
        chk("req2_id", id, 2);
        chk("req2_res", last_res, 32'd100000);

        // All four signed 10 * -5 right after reset.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 16'h000A, 16'hFFFB, 1'b1);
        req_valid = 4'b1111;
        for (int k = 0; k < N; k++) begin
            run_txn(0, '0, id, w);
            chk("rr_order", id, k);
            chk("neg_prod", last_res, 32'hFFFFFFCE);
            if (k > 0) chk("b2b_grant", w, 0);
        end

        // Requesters 1 and 3 held continuously.
        set_req(1, 16'd300, 16'd5, 1'b0);
        set_req(3, 16'hFFFF, 16'd2, 1'b1);
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            run_txn(0, 4'b1010, id, w);
            chk("alt_order", id, (k % 2 == 0) ? 1 : 3);
        end
        req_valid = '0;

        // Slow consumer with a competing request pending.
        set_req(0, 16'd1234, 16'd56, 1'b0);
        set_req(1, 16'h8000, 16'h8000, 1'b1);
        req_valid = 4'b0011;
        run_txn(5, '0, id, w);
        chk("slow_id0", id, 0);
        run_txn(0, '0, id, w);
        chk("slow_id1", id, 1);
        chk("min_sq", last_res, 32'h40000000);

        // Reset during WAIT abandons the operation.
        set_req(0, 16'd11, 16'd13, 1'b0);
        req_valid = 4'b0001;
        #1;
        chk("rw_grant", req_ready, 4'b0001);
        @(negedge clk);
        #1;
        chk("rw_start", mul_start, 1);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_zero("rst_wait");
        @(negedge clk);
        rst   = 1'b0;
        ptr_m = 0;
        quiet = 1;
        repeat (10) begin
            #1;
            if (rsp_valid !== 1'b0) quiet = 0;
            @(negedge clk);
        end
        chk("rst_no_rsp", quiet, 1);
        set_req(1, 16'hFFFF, 16'hFFFF, 1'b0);
        req_valid = 4'b0010;
        run_txn(2, '0, id, w);
        chk("ffff_id", id, 1);
        chk("ffff_res", last_res, 32'hFFFE0001);

        // Random traffic; requesters may withdraw between grants.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 16'($urandom), 16'($urandom), 1'($urandom));
            mask = 4'($urandom_range(1, 15));
            req_valid = mask;
            run_txn($urandom_range(0, 3), '0, id, w);
        end
        req_valid = '0;

`ifdef MULT_SCHED_TIMEOUT_EN
        // Multiplier never finishes: watchdog abort after 64 WAIT cycles.
        no_done = 1'b1;
        do_reset();
        set_req(2, 16'd3, 16'd4, 1'b0);
        req_valid = 4'b0100;
        #1;
        chk("to_grant", req_ready, 4'b0100);
        @(negedge clk);
        #1;
        chk("to_start", mul_start, 1);
        n0 = ncyc;
        req_valid = '0;
        w = 0;
        while (rsp_valid !== 1'b1 && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("to_valid", rsp_valid, 1);
        chk("to_cycles", ncyc - n0, 65);
        chk("to_err", rsp_err, 1);
        chk("to_res", rsp_result, 0);
        chk("to_id", rsp_id, 2);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        no_done   = 1'b0;
        do_reset();
`else
        n0 = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter: WIDTH, 16, operand width; SHALL equal the WIDTH of the shared shift_add_mult instance.
REQ-002 Parameter: NUM_REQ, 4, number of requesters (1..16).
REQ-003 Parameter: TIMEOUT, 64, watchdog limit in cycles (used only with MULT_SCHED_TIMEOUT_EN).
REQ-004 Derived: IDW = max(1, clog2(NUM_REQ)).
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 req_valid  input  NUM_REQ  per-requester request.
REQ-008 req_ready  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-009 req_a  input  NUM_REQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
REQ-010 req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a.
REQ-011 req_signed  input  NUM_REQ  per-requester signed_mode.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed.
REQ-014 rsp_id  output  IDW  index of the requester owning the response.
REQ-015 rsp_result  output  2*WIDTH  product.
REQ-016 rsp_err  output  1  watchdog abort flag.
REQ-017 mul_start, mul_valid_in  output  1 each  to multiplier start/valid_in.
REQ-018 mul_a, mul_b  output  WIDTH each  to multiplier A/B.
REQ-019 mul_signed  output  1  to multiplier signed_mode.
REQ-020 mul_result  input  2*WIDTH; mul_done  input  1; mul_busy  input  1  from multiplier.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: when any req_valid is high and mul_busy=0, the block SHALL assert req_ready for the single round-robin winner and register its operands, signed bit and index, then go to ISSUE.
REQ-023 Round-robin: the search SHALL start at pointer ptr and scan upward modulo NUM_REQ; ptr SHALL become winner+1 (mod NUM_REQ) when the response is consumed; NUM_REQ=1 keeps ptr=0.
REQ-024 ISSUE: mul_start and mul_valid_in SHALL be high for exactly one cycle with registered operands on mul_a, mul_b and mul_signed, then go to WAIT.
REQ-025 mul_a, mul_b and mul_signed SHALL hold their values from ISSUE through WAIT.
REQ-026 WAIT: on mul_done=1 the block SHALL capture mul_result into rsp_result, assert rsp_valid the next cycle, and go to RESP.
REQ-027 RESP: rsp_valid, rsp_id, rsp_result and rsp_err SHALL stay stable until rsp_ready=1; then rsp_valid drops and the state returns to IDLE.
REQ-028 Latency: accept at edge T, mul_start high in cycle T+1, rsp_valid high in the cycle after mul_done.
REQ-029 No new request SHALL be accepted outside IDLE, so at most one operation is outstanding.
REQ-030 mul_done seen in IDLE, ISSUE or RESP SHALL be ignored.
REQ-031 A requester dropping req_valid before its grant SHALL be legal, and its request is simply not served.
REQ-032 If rsp_ready is high in the first RESP cycle, the block SHALL return to IDLE and may grant again in the following cycle.

Reset
REQ-033 While rst=1 at a clock edge, the state SHALL become IDLE, ptr=0, and outputs SHALL clear: req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, mul_start=0, mul_valid_in=0, mul_a=0, mul_b=0, mul_signed=0.
REQ-034 Reset mid-operation (ISSUE/WAIT/RESP) SHALL abandon the operation without emitting a response.

Configuration
REQ-035 Macro MULT_SCHED_TIMEOUT_EN defined: a counter SHALL run in WAIT; if mul_done is absent for TIMEOUT cycles, the block SHALL enter RESP with rsp_result=0 and rsp_err=1. rsp_err SHALL be 0 on normal completion.
REQ-036 Macro MULT_SCHED_TIMEOUT_EN undefined: no counter, WAIT persists until mul_done, and rsp_err SHALL be tied 0.

Verification (WIDTH=16, NUM_REQ=4, real shift_add_mult with PARALLEL_OPS=4)
REQ-037 Requester 2 alone, A=1000, B=100, unsigned -> one mul_start pulse; rsp_id=2, rsp_result=100000, rsp_err=0.
REQ-038 All four valid simultaneously after reset, each signed with A=0x000A, B=0xFFFB -> grants in order 0,1,2,3; each rsp_result=0xFFFFFFCE.
REQ-039 Requesters 1 and 3 held continuously -> grants alternate 1,3,1,3 with no starvation.
REQ-040 rsp_ready held low for 5 cycles in RESP -> rsp outputs stable, no new req_ready and no mul_start until consumed.
REQ-041 rst pulsed during WAIT -> all outputs zero next cycle, no response; a following request 0xFFFF x 0xFFFF unsigned yields 0xFFFE0001.
REQ-042 With MULT_SCHED_TIMEOUT_EN, mul_done forced low -> after 64 WAIT cycles rsp_valid=1, rsp_err=1, rsp_result=0.
